// File: rtl/input_controller.sv
// NES pad poller: a free-running poll counter kicks off a latch/pulse read of the
// 8 serial button bits, which are debounced once per poll into an active-high byte.
module input_controller #(
  parameter int POLL_BITS    = 19,
  parameter int LATCH_CYCLES = 480,
  parameter int HALF_CYCLES  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_data,
  output logic       latch,
  output logic       pulse,
  output logic       latch_tb,
  output logic       slow_clk_tb,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic [7:0] new_press
);

  localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, LATCH, LOW0, PHIGH, PLOW, DONE} state_t;

  state_t                 state, state_n;
  logic [POLL_BITS-1:0]   poll_cnt;
  logic [CW-1:0]          phase_cnt;
  logic [2:0]             index;
  logic [7:0]             shift_reg;
  logic [1:0]             sync;
  logic                   last_latch, last_half;
  logic [7:0]             captured;

  assign last_latch  = (phase_cnt == CW'(LATCH_CYCLES - 1));
  assign last_half   = (phase_cnt == CW'(HALF_CYCLES - 1));
  // Full frame as it will look once bit 7 lands on this edge.
  assign captured    = {sync[1], shift_reg[6:0]};
  assign latch_tb    = latch;
  assign slow_clk_tb = poll_cnt[POLL_BITS-1];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (&poll_cnt) state_n = LATCH;
      LATCH:   if (last_latch) state_n = LOW0;
      LOW0:    if (last_half) state_n = PHIGH;
      PHIGH:   if (last_half) state_n = PLOW;
      PLOW:    if (last_half) state_n = (index == 3'd7) ? DONE : PHIGH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      phase_cnt     <= '0;
      index         <= '0;
      shift_reg     <= 8'hFF;
      sync          <= 2'b11;
      latch         <= 1'b0;
      pulse         <= 1'b0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      new_press     <= '0;
    end else begin
      poll_cnt      <= poll_cnt + 1'b1;
      sync          <= {sync[0], button_data};
      state         <= state_n;
      phase_cnt     <= (state_n != state) ? '0 : phase_cnt + CW'(1);
      // Strobes are decoded from the next state so they leave a flop cleanly.
      latch         <= (state_n == LATCH);
      pulse         <= (state_n == PHIGH);
      buttons_valid <= 1'b0;
      new_press     <= '0;
      if (state == LOW0 && last_half) begin
        shift_reg[0] <= sync[1];
        index        <= 3'd1;
      end
      if (state == PLOW && last_half) begin
        shift_reg[index] <= sync[1];
        if (index != 3'd7) begin
          index <= index + 3'd1;
        end else begin
          // Publish alongside entry to DONE so the strobe marks the DONE cycle.
          buttons       <= ~captured;
          buttons_valid <= 1'b1;
          new_press     <= ~captured & ~buttons;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_controller.sv
// Bench for input_controller: poll-timing model derived from cycle arithmetic,
// a pad model driven by the observed latch/pulse, and directed button patterns.
module tb_input_controller;
  localparam int PB  = 13;
  localparam int P   = 1 << PB;
  localparam int LC  = 480;
  localparam int HC  = 240;
  localparam int TXN = LC + HC + 7 * 2 * HC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button_data = 1'b1;
  logic       latch, pulse, latch_tb, slow_clk_tb, buttons_valid;
  logic [7:0] buttons, new_press;

  input_controller #(.POLL_BITS(PB), .LATCH_CYCLES(LC), .HALF_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .button_data(button_data),
    .latch(latch), .pulse(pulse), .latch_tb(latch_tb), .slow_clk_tb(slow_clk_tb),
    .buttons(buttons), .buttons_valid(buttons_valid), .new_press(new_press)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         n = 0;
  logic [7:0] m_buttons = 8'h00;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] pad_pat = 8'h00;
  bit         exact = 1'b0;
  int         pad_idx = 0;
  logic       prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (n=%0d)", name, got, exp, n);
    end
  endtask

  // n = rising edges since reset release; a read starts every P edges.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n <= 0; m_buttons <= 8'h00; m_prev <= 8'h00;
    end else begin
      n <= n + 1;
      if (n + 1 >= P && (n + 1) % P == TXN) begin
        m_prev    <= m_buttons;
        m_buttons <= pad_pat;
      end
    end
  end

  function automatic logic [20:0] expected(input int nn);
    int   pw;
    bit   act, el, ep, ev, es;
    pw  = nn % P;
    act = nn >= P;
    el  = act && pw < LC;
    ep  = act && pw >= LC + HC && pw < TXN && ((pw - LC - HC) % (2 * HC)) < HC;
    ev  = act && pw == TXN;
    es  = ((pw >> (PB - 1)) & 1) != 0;
    return {el, ep, el, es, ev, (ev ? (m_buttons & ~m_prev) : 8'h00), m_buttons};
  endfunction

  always @(negedge clk) begin
    check("outputs", {latch, pulse, latch_tb, slow_clk_tb, buttons_valid, new_press, buttons},
          expected(n));
  end

  // Exact mode: the correct bit is presented for exactly one cycle, the one that
  // reaches the sampler through both sync flops on the final LOW0/PLOW edge.
  function automatic logic exact_bit(input int nn);
    int pw, k;
    bit hit;
    pw = nn % P;
    if (nn < P) return 1'b1;
    k   = (pw <= LC + HC - 3) ? 0 : (pw - (LC + HC - 2)) / (2 * HC) + 1;
    if (k > 7) k = 7;
    hit = pw >= LC + HC - 3 && ((pw - (LC + HC - 3)) % (2 * HC)) == 0;
    return hit ? ~pad_pat[k] : pad_pat[k];
  endfunction

  always @(negedge clk) begin
    if (latch) pad_idx = 0;
    else if (pulse && !prev_pulse) pad_idx++;
    prev_pulse = pulse;
    if (exact) button_data = exact_bit(n);
    else       button_data = (pad_idx < 8) ? ~pad_pat[pad_idx] : 1'b0;
  end

  int   last_tog = -1;
  logic last_slow = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      last_tog = -1; last_slow = 1'b0;
    end else if (slow_clk_tb !== last_slow) begin
      if (last_tog >= 0) check("slow_period", n - last_tog, P / 2);
      last_tog  = n;
      last_slow = slow_clk_tb;
    end
  end

  task automatic wait_valid();
    int c = 0;
    @(negedge clk);
    while (!buttons_valid && c < 2 * P) begin
      @(negedge clk); c++;
    end
    check("valid_strobe", buttons_valid, 1);
  endtask

  task automatic count_to_latch(input string name);
    int c = 0;
    while (!latch && c < P + 16) begin
      @(negedge clk); c++;
    end
    check(name, c, P);
  endtask

  initial begin
    int c, lh, np, r;
    logic pv;
    repeat (4) @(negedge clk);
    check("reset_outs", {latch, pulse, buttons_valid, new_press, buttons, slow_clk_tb}, 0);

    // No pad: all released.
    reset = 1'b1;
    count_to_latch("first_latch_cycle");
    lh = 0;
    while (latch && lh < LC + 16) begin
      lh++; @(negedge clk);
    end
    check("latch_high_len", lh, LC);
    np = 0; pv = 1'b0; c = 0;
    while (!buttons_valid && c < P) begin
      if (pulse && !pv) np++;
      pv = pulse; @(negedge clk); c++;
    end
    check("pulse_count", np, 7);
    check("idle_valid", buttons_valid, 1);
    check("idle_buttons", buttons, 8'h00);

    pad_pat = 8'h01;
    wait_valid();
    check("a_buttons", buttons, 8'h01);
    check("a_new_press", new_press, 8'h01);

    wait_valid();
    check("a2_buttons", buttons, 8'h01);
    check("a2_new_press", new_press, 8'h00);

    pad_pat = 8'h48; exact = 1'b1;
    wait_valid();
    check("ls_buttons", buttons, 8'h48);
    check("ls_new_press", new_press, 8'h48);
    exact = 1'b0;

    // Abort during the 4th pulse-high phase.
    pad_pat = 8'hFF;
    r = 0; c = 0; pv = pulse;
    while (r < 4 && c < 2 * P) begin
      @(negedge clk); c++;
      if (pulse && !pv) r++;
      pv = pulse;
    end
    check("reached_pulse4", r, 4);
    repeat (20) @(negedge clk);
    check("pre_abort_buttons", buttons, 8'h48);
    #2 reset = 1'b0;
    #1 check("abort_outs", {latch, pulse, buttons_valid, new_press, buttons}, 0);
    repeat (5) @(negedge clk);
    check("abort_held", buttons, 8'h00);
    pad_pat = 8'h81;
    reset = 1'b1;
    count_to_latch("latch_after_abort");
    wait_valid();
    check("post_buttons", buttons, 8'h81);
    check("post_new_press", new_press, 8'h81);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at n=%0d", n);
    $fatal(1, "watchdog");
  end

endmodule
